mem_cmd_arbiter: RTL and testbench
==================================

Name: mem_cmd_arbiter

Overview:
- Round-robin arbiter and sequencer that lets NUM_REQ requesters share the single memory controller command port.
- Requesters include the button/switch I/O controller and a background clear/scrub engine.
- Latches one requester's command, address and write data, then launches it to the memory controller with a one-cycle strobe.
- Waits for the completion pulse, then returns read data and a done pulse to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 64, memory address width.
- DATA_W, 32, memory data width.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request. Held high until the matching req_ack.
- req_cmd  in  2*NUM_REQ  per-requester command: 00 clear, 01 write, 10 read, 11 nop/reset.
- req_addr  in  ADDR_W*NUM_REQ  per-requester address.
- req_wdata  in  DATA_W*NUM_REQ  per-requester write data.
- req_ack  out  NUM_REQ  one-cycle pulse: request latched.
- resp_done  out  NUM_REQ  one-cycle pulse: request completed.
- resp_data  out  DATA_W  read data from the last completed read.
- resp_err  out  1  one-cycle pulse with resp_done on timeout abort.
- grant_id  out  3  index of the current or last winner.
- busy  out  1  high in any state other than IDLE.
- mem_cmd  out  2  command to the memory controller.
- mem_addr  out  ADDR_W  address to the memory controller.
- mem_wdata  out  DATA_W  write data to the memory controller.
- mem_cmd_valid  out  1  one-cycle launch strobe.
- mem_done_in  in  1  one-cycle completion pulse from the memory controller.
- mem_rdata  in  DATA_W  read data, valid in the mem_done_in cycle.

Behaviour:
- Reset values (rst_n low at a clk edge):
  - mem_cmd=2'b11; mem_addr=0; mem_wdata=0; mem_cmd_valid=0.
  - req_ack=0; resp_done=0; resp_data=0; resp_err=0; grant_id=0; busy=0.
  - FSM=IDLE; round-robin pointer=NUM_REQ-1, so requester 0 has highest priority first.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching upward (with wrap) from pointer+1.
  - On that edge: latch the winner's cmd/addr/wdata into mem_cmd/mem_addr/mem_wdata, set grant_id, pulse req_ack[winner], go ISSUE.
  - Nothing valid: stay in IDLE.
- ISSUE:
  - Cmd 00/01/10: mem_cmd_valid=1 for exactly this one cycle, then go WAIT.
  - Cmd 11: no strobe; pulse resp_done[winner], update pointer, return to IDLE.
- WAIT:
  - mem_done_in is sampled only in this state.
  - On mem_done_in: pulse resp_done[winner]; update pointer=winner; go IDLE.
  - If the command was a read, also capture mem_rdata into resp_data.
- resp_data holds its value across clear/write/nop completions.
- mem_done_in in IDLE or ISSUE is ignored, with no state change.
- Output registers mem_cmd/mem_addr/mem_wdata hold their values until the next grant.
- Latency:
  - req_valid high in cycle N → req_ack in cycle N+1 → mem_cmd_valid in cycle N+2.
  - resp_done follows mem_done_in by 1 cycle.
- Grant spacing: minimum 3 cycles plus memory latency.
- A requester dropping req_valid after req_ack does not affect the in-flight transaction.
- A requester re-asserting req_valid immediately is serviced only after all other waiting requesters (fairness).
- Reset mid-transaction: the in-flight command is abandoned, no resp_done is issued, and all outputs return to reset values.
- grant_id width is fixed at 3 bits; unused upper bits are 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mem_done_in: pulse resp_done[winner] and resp_err together, leave resp_data unchanged, update pointer, go IDLE.
  - mem_done_in in the same cycle as the counter reaching the limit wins: normal completion, resp_err=0.
- Not defined: no counter; WAIT waits indefinitely; resp_err is tied to 0.

Test Plan:
- Reset, then req_valid=2'b01, req_cmd=01, addr=0x10, wdata=0xDEADBEEF.
  - Required: req_ack[0] at +1, and mem_cmd_valid at +2 with mem_cmd=01, mem_addr=0x10, mem_wdata=0xDEADBEEF.
  - mem_done_in at +5 → resp_done[0] at +6.
- Read cmd 10, addr 0x20, mem_rdata=0x12345678 with mem_done_in → resp_data=0x12345678 one cycle later. A following write completion leaves resp_data=0x12345678.
- Both requesters valid continuously after reset → grant order 0,1,0,1 (grant_id sequence 0,1,0,1), each completed via mem_done_in.
- req_cmd=11 from requester 1 → req_ack[1], then resp_done[1] the next cycle. mem_cmd_valid never asserts.
- rst_n low for 1 cycle while in WAIT, followed by mem_done_in → no resp_done; outputs at reset values; busy=0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no mem_done_in → resp_done and resp_err pulse 8 cycles after WAIT entry, and busy drops.

Source files
------------

// File: rtl/mem_cmd_arbiter.sv
// mem_cmd_arbiter: round-robin arbiter/sequencer sharing one memory controller
// command port among NUM_REQ requesters. A winner's cmd/addr/wdata are latched
// in IDLE, launched with a one-cycle strobe in ISSUE, and completed in WAIT on
// mem_done_in. Optional watchdog abort in WAIT: define MEM_ARB_TIMEOUT_EN.
module mem_cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        resp_done,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic [1:0]                mem_cmd,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_cmd_valid,
  input  logic                      mem_done_in,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam logic [1:0]         CMD_READ = 2'b10;
  localparam logic [1:0]         CMD_NOP  = 2'b11;
  localparam logic [2:0]         LAST     = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_next;
  logic [2:0]  ptr;
  logic [2:0]  win;
  logic        found;
  logic [2:0]  cur;
  logic [7:0]  valid8;
  logic        grant, launch, complete, capture;

  // Per-requester fields unpacked into 8-deep arrays so a 3-bit index always
  // fits; unused slots look like idle nop requesters.
  logic [1:0]        cmd_a   [8];
  logic [ADDR_W-1:0] addr_a  [8];
  logic [DATA_W-1:0] wdata_a [8];

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_cmd_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  for (genvar g = 0; g < 8; g++) begin : g_unpack
    if (g < NUM_REQ) begin : g_used
      assign cmd_a[g]   = req_cmd[2*g +: 2];
      assign addr_a[g]  = req_addr[ADDR_W*g +: ADDR_W];
      assign wdata_a[g] = req_wdata[DATA_W*g +: DATA_W];
    end else begin : g_pad
      assign cmd_a[g]   = CMD_NOP;
      assign addr_a[g]  = '0;
      assign wdata_a[g] = '0;
    end
  end

  assign valid8 = 8'(req_valid);
  assign busy   = (state != IDLE);

  // Round-robin search: first valid requester strictly after ptr, with wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cur   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur = (cur == LAST) ? 3'd0 : cur + 3'd1;
      if (!found && valid8[cur]) begin
        found = 1'b1;
        win   = cur;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_hit;

  // mem_done_in in the limit cycle takes precedence over the abort.
  assign timeout_hit = (state == WAIT) && !mem_done_in &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared on the launch edge, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_err <= timeout_hit;
      if (launch)
        tmo_cnt <= '0;
      else if (state == WAIT)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    launch     = 1'b0;
    complete   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_cmd == CMD_NOP) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else begin
          launch     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_done_in) begin
          complete   = 1'b1;
          capture    = (mem_cmd == CMD_READ);
          state_next = IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch on grant, strobe on launch, respond on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_cmd       <= CMD_NOP;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_cmd_valid <= 1'b0;
      req_ack       <= '0;
      resp_done     <= '0;
      resp_data     <= '0;
      grant_id      <= '0;
      ptr           <= LAST;
    end else begin
      req_ack       <= '0;
      resp_done     <= '0;
      mem_cmd_valid <= launch;
      if (grant) begin
        mem_cmd   <= cmd_a[win];
        mem_addr  <= addr_a[win];
        mem_wdata <= wdata_a[win];
        grant_id  <= win;
        req_ack   <= ONE << win;
      end
      if (complete) begin
        resp_done <= ONE << grant_id;
        ptr       <= grant_id;
      end
      if (capture)
        resp_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Directed testbench for mem_cmd_arbiter (2 requesters). Inputs are driven
// 1 ns after each rising edge, outputs checked at the same point.
module tb_mem_cmd_arbiter;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [2*NR-1:0]  req_cmd;
  logic [AW*NR-1:0] req_addr;
  logic [DW*NR-1:0] req_wdata;
  logic [NR-1:0]    req_ack;
  logic [NR-1:0]    resp_done;
  logic [DW-1:0]    resp_data;
  logic             resp_err;
  logic [2:0]       grant_id;
  logic             busy;
  logic [1:0]       mem_cmd;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_cmd_valid;
  logic             mem_done_in;
  logic [DW-1:0]    mem_rdata;

  int cmp_cnt = 0;
  int err_cnt = 0;

  mem_cmd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .resp_done(resp_done), .resp_data(resp_data), .resp_err(resp_err),
    .grant_id(grant_id), .busy(busy), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_cmd_valid(mem_cmd_valid),
    .mem_done_in(mem_done_in), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_cmd = '1; req_addr = '0; req_wdata = '0;
    mem_done_in = 1'b0; mem_rdata = '0;
    do_reset();
    cmp_cnt++;
    if ({mem_cmd, mem_cmd_valid, req_ack, resp_done, resp_err, grant_id, busy} !== {2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_ctrl: cmd=%b v=%b ack=%b done=%b err=%b gid=%0d busy=%b, want cmd=11 rest 0",
               mem_cmd, mem_cmd_valid, req_ack, resp_done, resp_err, grant_id, busy);
    end
    cmp_cnt++;
    if ({mem_addr, mem_wdata, resp_data} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want all 0", mem_addr, mem_wdata, resp_data);
    end
  endtask

  task automatic test_write();
    req_valid = 2'b01; req_cmd = 4'b0001;
    req_addr = {64'h0, 64'h10}; req_wdata = {32'h0, 32'hDEADBEEF};
    tick(); // N+1
    cmp_cnt++;
    if ({req_ack, grant_id, busy, mem_cmd_valid} !== {2'b01, 3'd0, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL wr_ack: ack=%b gid=%0d busy=%b v=%b, want ack=01 gid=0 busy=1 v=0",
               req_ack, grant_id, busy, mem_cmd_valid);
    end
    req_valid = 2'b00;
    req_addr = '0; req_wdata = '0; // changes after ack must not reach the memory port
    tick(); // N+2
    cmp_cnt++;
    if ({mem_cmd_valid, mem_cmd, mem_addr, mem_wdata} !== {1'b1, 2'b01, 64'h10, 32'hDEADBEEF}) begin
      err_cnt++;
      $display("FAIL wr_launch: v=%b cmd=%b addr=%h wdata=%h, want v=1 cmd=01 addr=10 wdata=deadbeef",
               mem_cmd_valid, mem_cmd, mem_addr, mem_wdata);
    end
    tick(); // N+3
    cmp_cnt++;
    if ({mem_cmd_valid, busy, resp_done} !== {1'b0, 1'b1, 2'b00}) begin
      err_cnt++;
      $display("FAIL wr_strobe_once: v=%b busy=%b done=%b, want v=0 busy=1 done=00", mem_cmd_valid, busy, resp_done);
    end
    tick(); // N+4
    tick(); // N+5
    mem_done_in = 1'b1;
    tick(); // N+6
    mem_done_in = 1'b0;
    cmp_cnt++;
    if ({resp_done, busy, resp_err} !== {2'b01, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL wr_done: done=%b busy=%b err=%b, want done=01 busy=0 err=0", resp_done, busy, resp_err);
    end
    tick();
    cmp_cnt++;
    if ({resp_done, mem_cmd, mem_addr} !== {2'b00, 2'b01, 64'h10}) begin
      err_cnt++;
      $display("FAIL wr_hold: done=%b cmd=%b addr=%h, want done=00 cmd=01 addr=10", resp_done, mem_cmd, mem_addr);
    end
    // completion pulse while idle is ignored
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    cmp_cnt++;
    if ({resp_done, busy} !== {2'b00, 1'b0}) begin
      err_cnt++;
      $display("FAIL idle_done_ignored: done=%b busy=%b, want 00/0", resp_done, busy);
    end
  endtask

  task automatic test_read_hold();
    req_valid = 2'b01; req_cmd = 4'b0010; req_addr = {64'h0, 64'h20};
    tick(); // ack
    req_valid = 2'b00;
    tick(); // launch
    cmp_cnt++;
    if ({mem_cmd_valid, mem_cmd, mem_addr} !== {1'b1, 2'b10, 64'h20}) begin
      err_cnt++;
      $display("FAIL rd_launch: v=%b cmd=%b addr=%h, want v=1 cmd=10 addr=20", mem_cmd_valid, mem_cmd, mem_addr);
    end
    tick();
    mem_done_in = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_done_in = 1'b0; mem_rdata = 32'hAAAA5555;
    cmp_cnt++;
    if ({resp_done, resp_data} !== {2'b01, 32'h12345678}) begin
      err_cnt++;
      $display("FAIL rd_data: done=%b data=%h, want done=01 data=12345678", resp_done, resp_data);
    end
    // requester 1 write; resp_data must not change
    req_valid = 2'b10; req_cmd = 4'b0100;
    req_addr = {64'h44, 64'h0}; req_wdata = {32'hCAFEF00D, 32'h0};
    tick();
    cmp_cnt++;
    if ({req_ack, grant_id} !== {2'b10, 3'd1}) begin
      err_cnt++;
      $display("FAIL wr1_ack: ack=%b gid=%0d, want ack=10 gid=1", req_ack, grant_id);
    end
    req_valid = 2'b00;
    tick();
    tick();
    mem_done_in = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_done_in = 1'b0;
    cmp_cnt++;
    if ({resp_done, resp_data, mem_wdata} !== {2'b10, 32'h12345678, 32'hCAFEF00D}) begin
      err_cnt++;
      $display("FAIL rd_data_hold: done=%b data=%h wdata=%h, want done=10 data=12345678 wdata=cafef00d",
               resp_done, resp_data, mem_wdata);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 2'b11; req_cmd = 4'b0101;
    req_addr = {64'hB0, 64'hA0}; req_wdata = {32'hB, 32'hA};
    for (int k = 0; k < 4; k++) begin
      int n;
      logic [2:0] exp_id;
      exp_id = 3'(k % 2);
      n = 0;
      while (req_ack === 2'b00 && n < 10) begin tick(); n++; end
      cmp_cnt++;
      if ({req_ack, grant_id} !== {2'b01 << exp_id, exp_id}) begin
        err_cnt++;
        $display("FAIL rr_grant%0d: ack=%b gid=%0d, want gid=%0d", k, req_ack, grant_id, exp_id);
      end
      n = 0;
      while (mem_cmd_valid !== 1'b1 && n < 10) begin tick(); n++; end
      mem_done_in = 1'b1;
      tick();
      mem_done_in = 1'b0;
      cmp_cnt++;
      if (resp_done !== (2'b01 << exp_id)) begin
        err_cnt++;
        $display("FAIL rr_done%0d: done=%b, want %b", k, resp_done, 2'b01 << exp_id);
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_nop();
    // pointer now at 1; lone requester 1 nop
    logic seen_strobe;
    seen_strobe = 1'b0;
    req_valid = 2'b10; req_cmd = 4'b1101;
    tick();
    seen_strobe |= mem_cmd_valid;
    cmp_cnt++;
    if ({req_ack, grant_id, mem_cmd} !== {2'b10, 3'd1, 2'b11}) begin
      err_cnt++;
      $display("FAIL nop_ack: ack=%b gid=%0d cmd=%b, want ack=10 gid=1 cmd=11", req_ack, grant_id, mem_cmd);
    end
    req_valid = 2'b00;
    tick();
    seen_strobe |= mem_cmd_valid;
    cmp_cnt++;
    if ({resp_done, busy} !== {2'b10, 1'b0}) begin
      err_cnt++;
      $display("FAIL nop_done: done=%b busy=%b, want done=10 busy=0", resp_done, busy);
    end
    tick();
    seen_strobe |= mem_cmd_valid;
    cmp_cnt++;
    if (seen_strobe !== 1'b0) begin
      err_cnt++;
      $display("FAIL nop_no_strobe: strobe seen=%b, want 0", seen_strobe);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_cmd = 4'b0001;
    req_addr = {64'h0, 64'h77}; req_wdata = {32'h0, 32'h99};
    tick();
    req_valid = 2'b00;
    tick(); // launch, WAIT
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    cmp_cnt++;
    if ({resp_done, busy, mem_cmd, mem_cmd_valid, grant_id, req_ack} !== {2'b00, 1'b0, 2'b11, 1'b0, 3'd0, 2'b00}) begin
      err_cnt++;
      $display("FAIL rst_mid_ctrl: done=%b busy=%b cmd=%b v=%b gid=%0d ack=%b, want done=00 busy=0 cmd=11 v=0 gid=0 ack=00",
               resp_done, busy, mem_cmd, mem_cmd_valid, grant_id, req_ack);
    end
    cmp_cnt++;
    if ({mem_addr, mem_wdata, resp_data} !== '0) begin
      err_cnt++;
      $display("FAIL rst_mid_data: addr=%h wdata=%h rdata=%h, want all 0", mem_addr, mem_wdata, resp_data);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic early;
    early = 1'b0;
    req_valid = 2'b01; req_cmd = 4'b0010; req_addr = {64'h0, 64'h30};
    tick();
    req_valid = 2'b00;
    tick(); // first WAIT cycle
    for (int i = 0; i < 7; i++) begin
      tick();
      early |= (resp_done != 2'b00) | resp_err;
    end
    tick(); // 8 cycles after WAIT entry
    cmp_cnt++;
    if ({early, resp_done, resp_err, busy, resp_data} !== {1'b0, 2'b01, 1'b1, 1'b0, 32'h0}) begin
      err_cnt++;
      $display("FAIL timeout: early=%b done=%b err=%b busy=%b data=%h, want early=0 done=01 err=1 busy=0 data=0",
               early, resp_done, resp_err, busy, resp_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_round_robin();
    test_nop();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
